// File: rtl/pkg_dvi_timing.sv
// 1080p60 CEA-861 timing constants, scan states and colour bars.
// Shared by the DVI timing generator and its counter.
package pkg_dvi_timing;

  localparam int unsigned T_H_ACTIVE = 1920;
  localparam int unsigned T_H_FP     = 88;
  localparam int unsigned T_H_SYNC   = 44;
  localparam int unsigned T_H_BP     = 148;
  localparam int unsigned T_V_ACTIVE = 1080;
  localparam int unsigned T_V_FP     = 4;
  localparam int unsigned T_V_SYNC   = 5;
  localparam int unsigned T_V_BP     = 36;
  localparam logic        T_SYNC_POL = 1'b1;

  localparam int unsigned T_H_TOTAL =
    T_H_ACTIVE + T_H_FP + T_H_SYNC + T_H_BP;
  localparam int unsigned T_V_TOTAL =
    T_V_ACTIVE + T_V_FP + T_V_SYNC + T_V_BP;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vid_state_t;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BARS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/pkg_mig_framebuffer.sv
// Framebuffer-side shared types.
// RGB888 pixel as carried on the read stream.
package pkg_mig_framebuffer;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } RGB888_t;

endpackage

// File: rtl/dvi_sync_counter.sv
// Raster h/v counters with raw DE, sync and end-of-frame decode.
// Counters hold at zero while clr is high and advance while en is high.
module dvi_sync_counter #(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL)
) (
  input  logic          clk_dvi,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          de_raw,
  output logic          hsync_raw,
  output logic          vsync_raw,
  output logic          eof
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  // raster scan: h wraps into v, v wraps at the last line
  always_ff @(posedge clk_dvi) begin
    if (rst || clr) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign de_raw    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hsync_raw = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vsync_raw = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign eof       = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/dvi_timing_pixel_pull.sv
// 1080p60 DVI timing generator pulling RGB888 from the framebuffer stream.
// Optional colour-bar generator under `define DVI_TEST_PATTERN_EN.
module dvi_timing_pixel_pull
  import pkg_mig_framebuffer::*;
  import pkg_dvi_timing::*;
#(
  parameter int unsigned H_ACTIVE = T_H_ACTIVE,
  parameter int unsigned H_FP     = T_H_FP,
  parameter int unsigned H_SYNC   = T_H_SYNC,
  parameter int unsigned H_BP     = T_H_BP,
  parameter int unsigned V_ACTIVE = T_V_ACTIVE,
  parameter int unsigned V_FP     = T_V_FP,
  parameter int unsigned V_SYNC   = T_V_SYNC,
  parameter int unsigned V_BP     = T_V_BP,
  parameter logic        SYNC_POL = T_SYNC_POL
) (
  input  logic    clk_dvi,
  input  logic    rst,
`ifdef DVI_TEST_PATTERN_EN
  input  logic    test_pattern,
`endif
  input  logic    framebuffer_ready,
  input  logic    framebuffer_valid,
  input  RGB888_t framebuffer_data,
  output logic    framebuffer_pull,
  output RGB888_t vid_rgb,
  output logic    vid_de,
  output logic    vid_hsync,
  output logic    vid_vsync,
  output logic    frame_start,
  output logic    underrun,
  input  logic    underrun_clr
);

  localparam int unsigned HW =
    $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int unsigned VW =
    $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

  vid_state_t    state;
  vid_state_t    state_n;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          de_raw;
  logic          hsync_raw;
  logic          vsync_raw;
  logic          eof;
  logic          live;
  logic          want_px;
  logic          miss;
  logic          tp_on;
  RGB888_t       px_next;

  dvi_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_cnt (
    .clk_dvi   (clk_dvi),
    .rst       (rst),
    .en        (live),
    .clr       (state == IDLE),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .de_raw    (de_raw),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .eof       (eof)
  );

`ifdef DVI_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  logic tp_q;
  logic [2:0] bar;

  // pattern select only changes while idle or on the frame boundary
  always_ff @(posedge clk_dvi) begin
    if (rst) begin
      tp_q <= 1'b0;
    end else if (state == IDLE || eof) begin
      tp_q <= test_pattern;
    end
  end

  assign tp_on = tp_q;
  assign bar   = 3'(h_cnt / HW'(BAR_W));
`else
  assign tp_on = 1'b0;
`endif

  assign live    = (state != IDLE);
  assign want_px = (state == RUN) && de_raw && !tp_on;
  assign miss    = want_px && !framebuffer_valid;

  assign framebuffer_pull = want_px && framebuffer_valid;

  // scan state register
  always_ff @(posedge clk_dvi) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // scan state transitions
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (framebuffer_ready) state_n = RUN;
      RUN:     if (!framebuffer_ready) state_n = DRAIN;
      DRAIN:   if (eof) state_n = framebuffer_ready ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
`ifdef DVI_TEST_PATTERN_EN
    if (tp_q || (state == IDLE && test_pattern)) state_n = RUN;
`endif
  end

  // pixel selected for the next output stage
  always_comb begin
    px_next = '0;
    if (framebuffer_pull) px_next = framebuffer_data;
`ifdef DVI_TEST_PATTERN_EN
    if (tp_on && state == RUN && de_raw) px_next = RGB888_t'(BARS[bar]);
`endif
  end

  // registered video bundle, one stage behind the counters
  always_ff @(posedge clk_dvi) begin
    if (rst) begin
      vid_rgb     <= '0;
      vid_de      <= 1'b0;
      vid_hsync   <= ~SYNC_POL;
      vid_vsync   <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      vid_rgb     <= px_next;
      vid_de      <= live && de_raw;
      vid_hsync   <= (live && hsync_raw) ? SYNC_POL : ~SYNC_POL;
      vid_vsync   <= (live && vsync_raw) ? SYNC_POL : ~SYNC_POL;
      frame_start <= (state == RUN) && (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // sticky underrun; a new miss beats a clear
  always_ff @(posedge clk_dvi) begin
    if (rst) begin
      underrun <= 1'b0;
    end else if (miss) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dvi_timing_pixel_pull.sv
// Randomized bench for dvi_timing_pixel_pull on a shrunken raster.
// Reference model tracks a linear frame position and scan mode.
module tb_dvi_timing_pixel_pull;

  localparam int HA = 16, HFP = 3, HS = 4, HBP = 5;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FR = HT * VT;
  localparam logic SP  = 1'b1;
  localparam logic NSP = ~SP;

  logic        clk_dvi = 1'b0;
  logic        rst = 1'b1;
  logic        test_pattern = 1'b0;
  logic        fb_ready = 1'b0;
  logic        fb_valid = 1'b0;
  logic [23:0] fb_data = '0;
  logic        ur_clr = 1'b0;
  logic        fb_pull;
  logic [23:0] vrgb;
  logic        vde, vhs, vvs, fs, ur;

  always #5 clk_dvi = ~clk_dvi;

  dvi_timing_pixel_pull #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .SYNC_POL (SP)
  ) dut (
    .clk_dvi           (clk_dvi),
    .rst               (rst),
`ifdef DVI_TEST_PATTERN_EN
    .test_pattern      (test_pattern),
`endif
    .framebuffer_ready (fb_ready),
    .framebuffer_valid (fb_valid),
    .framebuffer_data  (fb_data),
    .framebuffer_pull  (fb_pull),
    .vid_rgb           (vrgb),
    .vid_de            (vde),
    .vid_hsync         (vhs),
    .vid_vsync         (vvs),
    .frame_start       (fs),
    .underrun          (ur),
    .underrun_clr      (ur_clr)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef enum {M_IDLE, M_RUN, M_DRAIN} mode_e;
  mode_e       m_mode = M_IDLE;
  int          m_pos = 0;
  logic        e_de = 0, e_hs = NSP, e_vs = NSP, e_fs = 0, e_ur = 0;
  logic [23:0] e_rgb = '0;
  bit          popped = 0;
  bit          chk_en = 0;
  bit          rnd_valid = 0;
  int          n_pull = 0, n_de = 0, n_hs = 0, n_vs = 0;

  function automatic bit active(int p);
    return (p % HT) < HA && (p / HT) < VA;
  endfunction

  function automatic bit hs_on(int p);
    return (p % HT) >= HA + HFP && (p % HT) < HA + HFP + HS;
  endfunction

  function automatic bit vs_on(int p);
    return (p / HT) >= VA + VFP && (p / HT) < VA + VFP + VS;
  endfunction

  // reference model: advance one pixel clock
  always @(posedge clk_dvi) begin
    if (rst) begin
      m_mode = M_IDLE;
      m_pos  = 0;
      e_de = 0; e_hs = NSP; e_vs = NSP;
      e_fs = 0; e_ur = 0; e_rgb = '0;
    end else begin
      bit live, want;
      live  = (m_mode != M_IDLE);
      want  = (m_mode == M_RUN) && active(m_pos);
      e_de  = live && active(m_pos);
      e_hs  = (live && hs_on(m_pos)) ? SP : NSP;
      e_vs  = (live && vs_on(m_pos)) ? SP : NSP;
      e_fs  = (m_mode == M_RUN) && (m_pos == 0);
      e_rgb = (want && fb_valid) ? fb_data : 24'h0;
      if (want && !fb_valid) e_ur = 1;
      else if (ur_clr) e_ur = 0;
      popped = want && fb_valid;
      case (m_mode)
        M_IDLE:  if (fb_ready) m_mode = M_RUN;
        M_RUN:   if (!fb_ready) m_mode = M_DRAIN;
        M_DRAIN: if (m_pos == FR - 1)
                   m_mode = fb_ready ? M_RUN : M_IDLE;
        default: m_mode = M_IDLE;
      endcase
      m_pos = live ? (m_pos + 1) % FR : 0;
    end
  end

  // compare every cycle away from the active edge
  always @(negedge clk_dvi) begin
    if (chk_en) begin
      check("de", vde, e_de);
      check("hsync", vhs, e_hs);
      check("vsync", vvs, e_vs);
      check("frame_start", fs, e_fs);
      check("underrun", ur, e_ur);
      check("rgb", vrgb, e_rgb);
      check("pull", fb_pull,
            (m_mode == M_RUN) && active(m_pos) && fb_valid);
      n_pull += int'(fb_pull);
      n_de   += int'(vde);
      n_hs   += int'(vhs == SP);
      n_vs   += int'(vvs == SP);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_dvi);
      #1;
      if (popped) fb_data = fb_data + 1'b1;
      popped = 0;
      if (rnd_valid) fb_valid = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wait_at(input int h, input int v);
    int n = 0;
    while (m_pos != v * HT + h && n < 2 * FR) begin
      step();
      n++;
    end
    check("wait_bound", n < 2 * FR, 1);
  endtask

  initial begin
    int p0, d0, h0, s0;
    step();
    chk_en = 1;
    step(2);
    check("rst_de", vde, 0);
    check("rst_hs", vhs, NSP);
    check("rst_vs", vvs, NSP);
    check("rst_rgb", vrgb, 0);
    rst = 0;
    fb_valid = 1;
    step(4);
    check("idle_pull", fb_pull, 0);

    fb_ready = 1;
    step();
    check("fs_early", fs, 0);
    step();
    check("fs_first", fs, 1);
    check("first_de", vde, 1);
    check("first_rgb", vrgb, 0);
    step();
    check("second_rgb", vrgb, 1);

    wait_at(0, 0);
    p0 = n_pull; d0 = n_de; h0 = n_hs; s0 = n_vs;
    step(FR);
    check("pops_frame", n_pull - p0, HA * VA);
    check("de_frame", n_de - d0, HA * VA);
    check("hs_frame", n_hs - h0, HS * VT);
    check("vs_frame", n_vs - s0, VS * HT);

    wait_at(5, 2);
    fb_valid = 0;
    step(3);
    fb_valid = 1;
    step(2);
    check("ur_set", ur, 1);
    ur_clr = 1;
    step();
    ur_clr = 0;
    step();
    check("ur_clr", ur, 0);
    wait_at(3, 4);
    fb_valid = 0;
    ur_clr = 1;
    step();
    fb_valid = 1;
    ur_clr = 0;
    step();
    check("ur_coinc", ur, 1);

    rnd_valid = 1;
    step(2 * FR);
    rnd_valid = 0;
    fb_valid = 1;

    wait_at(0, 3);
    fb_ready = 0;
    step(2);
    check("drain_pull", fb_pull, 0);
    wait_at(0, 8);
    fb_ready = 1;
    wait_at(0, 0);
    step();
    check("redrain_fs", fs, 1);

    wait_at(0, 2);
    fb_ready = 0;
    wait_at(HT - 1, VT - 1);
    step(3);
    check("idle_de", vde, 0);
    check("idle_pull2", fb_pull, 0);
    step(FR / 2);
    check("idle_hold_vs", vvs, NSP);

    fb_ready = 1;
    wait_at(10, 4);
    rst = 1;
    step();
    rst = 0;
    check("rmid_de", vde, 0);
    check("rmid_rgb", vrgb, 0);
    check("rmid_hs", vhs, NSP);
    check("rmid_vs", vvs, NSP);
    check("rmid_fs", fs, 0);
    check("rmid_ur", ur, 0);
    check("rmid_pull", fb_pull, 0);
    step(FR);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dvi_timing_pixel_pull.md
Name: dvi_timing_pixel_pull

Overview:
Generates 1080p60 CEA-861 video timing on clk_dvi (148.5 MHz). Pulls RGB888 pixels from the framebuffer read stream (framebuffer_ready/pull/valid/data) during active video. Drives a registered RGB/DE/HSYNC/VSYNC bundle into hdmi_xmitter's TMDS encoders. Sits between framebuffer_Wishbone and hdmi_xmitter.

Parameters:
H_ACTIVE, 1920, active pixels per line
H_FP, 88, horizontal front porch
H_SYNC, 44, hsync width
H_BP, 148, horizontal back porch
V_ACTIVE, 1080, active lines
V_FP, 4, vertical front porch
V_SYNC, 5, vsync width
V_BP, 36, vertical back porch
SYNC_POL, 1'b1, sync active level (1 = positive)

Ports:
clk_dvi  in  1  pixel clock, 148.5 MHz
rst  in  1  synchronous, active-high reset
framebuffer_ready  in  1  framebuffer has a frame prefetched; start/continue scanning
framebuffer_valid  in  1  framebuffer_data holds a valid pixel (first-word-fall-through)
framebuffer_data  in  24  RGB888_t head pixel
framebuffer_pull  out  1  pops head pixel this cycle
vid_rgb  out  24  RGB888_t pixel to encoders
vid_de  out  1  data enable
vid_hsync  out  1  horizontal sync
vid_vsync  out  1  vertical sync
frame_start  out  1  one-cycle pulse at h=0,v=0 of each RUN frame
underrun  out  1  sticky: pixel needed but framebuffer_valid low
underrun_clr  in  1  clears underrun

Behaviour:
- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL=2200), v_cnt 0..V_TOTAL-1 (V_TOTAL=1125). Widths from $clog2 of the totals. h wraps to 0 and increments v; v wraps to 0 after 1124.
- Region order per line: active [0,H_ACTIVE), FP, SYNC, BP. Vertical uses the same order.
- hsync_raw = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync_raw is defined the same way on v_cnt.
- vsync changes at h_cnt=0 (no half-line offset).
- de_raw = h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- FSM states:
  - IDLE: counters held at 0. Outputs at blank levels. framebuffer_pull=0.
  - IDLE -> RUN when framebuffer_ready=1.
  - RUN: counters free-run.
  - RUN -> DRAIN when framebuffer_ready falls.
  - DRAIN: counters continue. framebuffer_pull=0. RGB forced 0; syncs still generated.
  - DRAIN -> IDLE at end of frame (h=H_TOTAL-1, v=V_TOTAL-1).
  - DRAIN -> RUN directly at that same boundary if framebuffer_ready=1 again.
- Pull: framebuffer_pull = (state==RUN) & de_raw & framebuffer_valid, combinational. Exactly one pop per active pixel when data is available.
- Underrun: in RUN with de_raw=1 and framebuffer_valid=0:
  - that pixel outputs 24'h000000 and nothing is popped;
  - underrun sets.
  - No resync; the frame continues.
- underrun_clr clears underrun. A simultaneous set wins.
- Latency: all vid_* outputs and frame_start are registered one stage after the counters. Pixel popped in cycle N appears on vid_rgb in cycle N+1, aligned with its vid_de.
- Reset values:
  - vid_rgb=0, vid_de=0.
  - vid_hsync=vid_vsync=~SYNC_POL.
  - frame_start=0, underrun=0, framebuffer_pull=0.
  - state=IDLE, counters=0.
- Reset mid-frame: next cycle in IDLE with all outputs at reset values. No partial-line completion.
- frame_start also fires on the first cycle of RUN entered from IDLE.

Optional Feature:
DVI_TEST_PATTERN_EN.
- Defined: adds input test_pattern (1 bit).
  - When test_pattern=1, vid_rgb shows 8 vertical colour bars of 240 pixels each. Order: white, yellow, cyan, green, magenta, red, blue, black. Bar index = h_cnt/240.
  - Timing runs regardless of framebuffer_ready; FSM forced to RUN.
  - framebuffer_pull=0; underrun is not updated.
  - Changes to test_pattern take effect at the next frame boundary.
- Undefined: no port; behaviour as above.

Decomposition:
- Existing pkg_mig_framebuffer already provides RGB888_t.
- New package pkg_dvi_timing holds:
  - 1080p60 timing constants and derived H_TOTAL/V_TOTAL;
  - the vid_state_t enum {IDLE, RUN, DRAIN};
  - colour-bar constant array.
- One sub-module, dvi_sync_counter: h/v counters plus raw de/hsync/vsync/end-of-frame decode, parameterised by the timing values.

Test Plan:
- Reset, ready=1, valid=1, incrementing data -> first frame_start one cycle after ready.
  - vid_de high 1920 cycles per line, 1080 lines.
  - hsync high for cycles 2008..2051 of each line.
  - vsync high for lines 1084..1088.
  - 2,073,600 pops per frame.
- Pixel order: data = 24-bit counter -> vid_rgb on each de cycle equals previous value +1. First pixel 0 appears exactly one cycle after its pull.
- valid low for 3 cycles at h=100, v=10 -> those 3 vid_rgb=0, no pulls there, underrun=1. underrun_clr -> 0. Clear coincident with a new miss -> stays 1.
- Drop ready at v=500 -> pulls stop immediately, syncs continue, IDLE after v=1124. Ready reasserted during DRAIN -> RUN at the frame boundary without an IDLE cycle.
- Assert rst at h=1000, v=700 -> next cycle all outputs at reset values, state IDLE.
- DVI_TEST_PATTERN_EN with test_pattern=1, ready=0 -> vid_rgb: FFFFFF at h=0, FFFF00 at h=240, 000000 at h=1680. No pulls issued.
